// File: rtl/pacman_move_ctrl.sv
// pacman_move_ctrl: per-sprite movement controller.
// It queries the valid-move detector once per TICK_DIV frames and waits for the
// one-hot answer. It holds a requested turn until that turn becomes legal, then
// steps the sprite position with wrap-around at the screen edges.
// Optional build macro: MOVE_TIMEOUT_EN. When defined, an outstanding query is
// abandoned after TIMEOUT_CYC cycles and q_err pulses. When undefined, REQ waits
// indefinitely and q_err is tied to 0.
module pacman_move_ctrl #(
   parameter logic [10:0] START_X     = 11'd320,
   parameter logic [9:0]  START_Y     = 10'd240,
   parameter logic [10:0] MAX_X       = 11'd639,
   parameter logic [9:0]  MAX_Y       = 10'd479,
   parameter logic [3:0]  STEP        = 4'd1,
   parameter logic [3:0]  TICK_DIV    = 4'd4,
   parameter logic [7:0]  TIMEOUT_CYC = 8'd64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_tick,
   input  logic [3:0]  dir_req,
   input  logic        dir_req_vld,
   output logic [10:0] query_x,
   output logic [9:0]  query_y,
   output logic        query_vld,
   input  logic [3:0]  moves,
   input  logic        moves_vld,
   output logic [10:0] pos_x,
   output logic [9:0]  pos_y,
   output logic [3:0]  cur_dir,
   output logic        stalled,
   output logic        step_done,
   output logic        q_err
);

   localparam logic [3:0] DIR_R = 4'b0001;
   localparam logic [3:0] DIR_U = 4'b0010;
   localparam logic [3:0] DIR_D = 4'b0100;
   localparam logic [3:0] DIR_L = 4'b1000;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_APPLY} state_t;

   state_t      r_state;
   logic [3:0]  r_tick_cnt;
   logic        r_pending;
   logic [3:0]  r_queued;
   logic [3:0]  r_cur_dir;
   logic [3:0]  r_moves;
   logic [10:0] r_pos_x;
   logic [9:0]  r_pos_y;
   logic [10:0] r_query_x;
   logic [9:0]  r_query_y;
   logic        r_query_vld;
   logic        r_stalled;
   logic        r_step_done;
`ifdef MOVE_TIMEOUT_EN
   logic [7:0]  r_to_cnt;
   logic        r_q_err;
`endif

   logic        w_req_onehot;
   logic        w_tick_expire;
   logic        w_take_pending;
   logic        w_apply;
   logic        w_queue_legal;
   logic [3:0]  w_eff_dir;
   logic        w_can_step;
   logic [10:0] w_x_inc;
   logic [10:0] w_x_dec;
   logic [10:0] w_y_inc;
   logic [10:0] w_y_dec;
   logic [10:0] w_next_x;
   logic [9:0]  w_next_y;
   logic        w_unused;

   // Add STEP; a result past vmax re-enters from 0 on the same axis.
   function automatic logic [10:0] f_inc_wrap(input logic [10:0] v, input logic [10:0] vmax);
      logic [11:0] sum;
      sum = {1'b0, v} + {8'b0, STEP};
      if (sum > {1'b0, vmax})
         sum = sum - {1'b0, vmax} - 12'd1;
      return sum[10:0];
   endfunction

   // Subtract STEP; going below 0 re-enters from vmax on the same axis.
   function automatic logic [10:0] f_dec_wrap(input logic [10:0] v, input logic [10:0] vmax);
      logic [11:0] res;
      if (v < {7'b0, STEP})
         res = {1'b0, vmax} + 12'd1 + {1'b0, v} - {8'b0, STEP};
      else
         res = {1'b0, v} - {8'b0, STEP};
      return res[10:0];
   endfunction

   assign w_req_onehot   = dir_req_vld && ((dir_req == DIR_R) || (dir_req == DIR_U) ||
                                           (dir_req == DIR_D) || (dir_req == DIR_L));
   assign w_tick_expire  = frame_tick && (r_tick_cnt == (TICK_DIV - 4'd1));
   assign w_take_pending = (r_state == S_IDLE) && r_pending;
   assign w_apply        = (r_state == S_APPLY);
   assign w_queue_legal  = |(r_queued & r_moves);
   assign w_eff_dir      = w_queue_legal ? r_queued : r_cur_dir;
   assign w_can_step     = |(w_eff_dir & r_moves);

   // The y axis runs through the 11-bit helpers zero-extended; results never exceed MAX_Y.
   assign w_x_inc = f_inc_wrap(r_pos_x, MAX_X);
   assign w_x_dec = f_dec_wrap(r_pos_x, MAX_X);
   assign w_y_inc = f_inc_wrap({1'b0, r_pos_y}, {1'b0, MAX_Y});
   assign w_y_dec = f_dec_wrap({1'b0, r_pos_y}, {1'b0, MAX_Y});
   assign w_unused = ^{w_y_inc[10], w_y_dec[10], TIMEOUT_CYC};

   // Candidate position for this attempt along the effective heading (screen y grows downward).
   always_comb begin
      w_next_x = r_pos_x;
      w_next_y = r_pos_y;
      if (w_can_step) begin
         case (w_eff_dir)
            DIR_R:   w_next_x = w_x_inc;
            DIR_L:   w_next_x = w_x_dec;
            DIR_D:   w_next_y = w_y_inc[9:0];
            DIR_U:   w_next_y = w_y_dec[9:0];
            default: ;
         endcase
      end
   end

   // Direction buffer: the latest one-hot request wins; it is consumed once it becomes the heading.
   always_ff @(posedge clk) begin
      if (rst)
         r_queued <= 4'b0000;
      else if (w_req_onehot)
         r_queued <= dir_req;
      else if (w_apply && w_queue_legal)
         r_queued <= 4'b0000;
   end

   // Frame divider: one pending attempt flag, never more than one outstanding.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tick_cnt <= 4'd0;
         r_pending  <= 1'b0;
      end else begin
         if (frame_tick)
            r_tick_cnt <= w_tick_expire ? 4'd0 : r_tick_cnt + 4'd1;
         if (w_tick_expire)
            r_pending <= 1'b1;
         else if (w_take_pending)
            r_pending <= 1'b0;
      end
   end

   // Query / answer / apply sequencer with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_query_x   <= START_X;
         r_query_y   <= START_Y;
         r_query_vld <= 1'b0;
         r_moves     <= 4'b0000;
         r_pos_x     <= START_X;
         r_pos_y     <= START_Y;
         r_cur_dir   <= 4'b0000;
         r_stalled   <= 1'b0;
         r_step_done <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
         r_to_cnt    <= 8'd0;
         r_q_err     <= 1'b0;
`endif
      end else begin
         r_step_done <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
         r_q_err     <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (r_pending) begin
                  r_query_x   <= r_pos_x;
                  r_query_y   <= r_pos_y;
                  r_query_vld <= 1'b1;
`ifdef MOVE_TIMEOUT_EN
                  r_to_cnt    <= 8'd0;
`endif
                  r_state     <= S_REQ;
               end
            end
            S_REQ: begin
               if (moves_vld) begin
                  r_moves     <= moves;
                  r_query_vld <= 1'b0;
                  r_state     <= S_APPLY;
               end
`ifdef MOVE_TIMEOUT_EN
               else if (r_to_cnt == (TIMEOUT_CYC - 8'd1)) begin
                  r_query_vld <= 1'b0;
                  r_q_err     <= 1'b1;
                  r_stalled   <= 1'b1;
                  r_state     <= S_IDLE;
               end else begin
                  r_to_cnt    <= r_to_cnt + 8'd1;
               end
`endif
            end
            S_APPLY: begin
               // A blocked attempt keeps the heading so it resumes once the way opens.
               r_cur_dir   <= w_eff_dir;
               r_pos_x     <= w_next_x;
               r_pos_y     <= w_next_y;
               r_stalled   <= ~w_can_step;
               r_step_done <= 1'b1;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign query_x   = r_query_x;
   assign query_y   = r_query_y;
   assign query_vld = r_query_vld;
   assign pos_x     = r_pos_x;
   assign pos_y     = r_pos_y;
   assign cur_dir   = r_cur_dir;
   assign stalled   = r_stalled;
   assign step_done = r_step_done;
`ifdef MOVE_TIMEOUT_EN
   assign q_err     = r_q_err;
`else
   assign q_err     = 1'b0;
`endif

endmodule

// File: tb/tb_pacman_move_ctrl.sv
// Directed bench for pacman_move_ctrl with hand-computed expected positions.
module tb_pacman_move_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        frame_tick;
   logic [3:0]  dir_req;
   logic        dir_req_vld;
   logic [3:0]  moves;
   logic        moves_vld;
   logic [10:0] query_x;
   logic [9:0]  query_y;
   logic        query_vld;
   logic [10:0] pos_x;
   logic [9:0]  pos_y;
   logic [3:0]  cur_dir;
   logic        stalled;
   logic        step_done;
   logic        q_err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pacman_move_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .frame_tick  (frame_tick),
      .dir_req     (dir_req),
      .dir_req_vld (dir_req_vld),
      .query_x     (query_x),
      .query_y     (query_y),
      .query_vld   (query_vld),
      .moves       (moves),
      .moves_vld   (moves_vld),
      .pos_x       (pos_x),
      .pos_y       (pos_y),
      .cur_dir     (cur_dir),
      .stalled     (stalled),
      .step_done   (step_done),
      .q_err       (q_err)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         frame_tick = 1'b1;
      end
      @(negedge clk);
      frame_tick = 1'b0;
   endtask

   task automatic req_dir(input logic [3:0] d);
      @(negedge clk);
      dir_req     = d;
      dir_req_vld = 1'b1;
      @(negedge clk);
      dir_req_vld = 1'b0;
      dir_req     = 4'b0000;
   endtask

   task automatic wait_query(input string tag);
      for (int i = 0; i < 8; i++) begin
         if (query_vld) break;
         @(negedge clk);
      end
      chk({tag, "_qvld"}, 32'(query_vld), 1);
   endtask

   // Answer the outstanding query and check the applied result.
   task automatic serve(input string tag, input logic [3:0] mv, input int qx, input int qy,
                        input int ex, input int ey, input int edir, input int est);
      wait_query(tag);
      chk({tag, "_qx"}, 32'(query_x), qx);
      chk({tag, "_qy"}, 32'(query_y), qy);
      moves     = mv;
      moves_vld = 1'b1;
      @(negedge clk);
      moves_vld = 1'b0;
      moves     = 4'b0000;
      chk({tag, "_qvld_lo"}, 32'(query_vld), 0);
      chk({tag, "_done_early"}, 32'(step_done), 0);
      @(negedge clk);
      chk({tag, "_done"}, 32'(step_done), 1);
      chk({tag, "_x"}, 32'(pos_x), ex);
      chk({tag, "_y"}, 32'(pos_y), ey);
      chk({tag, "_dir"}, 32'(cur_dir), edir);
      chk({tag, "_stall"}, 32'(stalled), est);
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(step_done), 0);
   endtask

   task automatic attempt(input string tag, input logic [3:0] mv, input int qx, input int qy,
                          input int ex, input int ey, input int edir, input int est);
      ticks(4);
      serve(tag, mv, qx, qy, ex, ey, edir, est);
   endtask

   task automatic step_quiet(input logic [3:0] mv);
      ticks(4);
      wait_query("walk");
      moves     = mv;
      moves_vld = 1'b1;
      @(negedge clk);
      moves_vld = 1'b0;
      moves     = 4'b0000;
      idle(2);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst         = 1'b1;
      frame_tick  = 1'b0;
      dir_req     = 4'b0000;
      dir_req_vld = 1'b0;
      moves       = 4'b0000;
      moves_vld   = 1'b0;
      idle(3);
      rst = 1'b0;

      // reset state
      chk("rst_x", 32'(pos_x), 320);
      chk("rst_y", 32'(pos_y), 240);
      chk("rst_dir", 32'(cur_dir), 0);
      chk("rst_qvld", 32'(query_vld), 0);
      chk("rst_stall", 32'(stalled), 0);
      chk("rst_done", 32'(step_done), 0);
      chk("rst_qerr", 32'(q_err), 0);

      // first attempt: query latency, then blocked with no heading
      ticks(4);
      chk("lat_n1", 32'(query_vld), 0);
      @(negedge clk);
      chk("lat_n2", 32'(query_vld), 1);
      serve("t1", 4'b0001, 320, 240, 320, 240, 0, 1);

      // queued right becomes legal
      req_dir(4'b0001);
      attempt("t2a", 4'b0011, 320, 240, 321, 240, 1, 0);
      attempt("t2b", 4'b0001, 321, 240, 322, 240, 1, 0);

      // queued up is held while illegal, then taken
      req_dir(4'b0010);
      attempt("t3a", 4'b0001, 322, 240, 323, 240, 1, 0);
      attempt("t3b", 4'b0010, 323, 240, 323, 239, 2, 0);

      // illegal requests ignored; blocked heading is kept
      req_dir(4'b0110);
      req_dir(4'b0000);
      attempt("t4", 4'b0100, 323, 239, 323, 239, 2, 1);

      // queued left survives illegal requests
      req_dir(4'b1000);
      req_dir(4'b0110);
      req_dir(4'b0000);
      attempt("t5a", 4'b1000, 323, 239, 322, 239, 8, 0);

      // latest request wins
      req_dir(4'b0001);
      req_dir(4'b0100);
      attempt("t5b", 4'b0101, 322, 239, 322, 240, 4, 0);

      // extra frame expiries while waiting give exactly one more attempt
      ticks(4);
      wait_query("t6w");
      ticks(8);
      chk("t6_held", 32'(query_vld), 1);
      serve("t6a", 4'b0100, 322, 240, 322, 241, 4, 0);
      serve("t6b", 4'b0100, 322, 241, 322, 242, 4, 0);
      idle(12);
      chk("t6_no_third", 32'(query_vld), 0);

      // walk right to the edge and wrap both ways
      req_dir(4'b0001);
      attempt("t7a", 4'b0001, 322, 242, 323, 242, 1, 0);
      for (int i = 0; i < 315; i++) step_quiet(4'b0001);
      chk("t7_walk_x", 32'(pos_x), 638);
      attempt("t7b", 4'b0001, 638, 242, 639, 242, 1, 0);
      attempt("t7c", 4'b0001, 639, 242, 0, 242, 1, 0);
      req_dir(4'b1000);
      attempt("t7d", 4'b1000, 0, 242, 639, 242, 8, 0);

      // reset while a query is outstanding
      req_dir(4'b0001);
      ticks(4);
      wait_query("t8w");
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t8_qvld", 32'(query_vld), 0);
      chk("t8_x", 32'(pos_x), 320);
      chk("t8_y", 32'(pos_y), 240);
      chk("t8_dir", 32'(cur_dir), 0);
      chk("t8_stall", 32'(stalled), 0);
      chk("t8_done", 32'(step_done), 0);
      chk("t8_qerr", 32'(q_err), 0);
      moves     = 4'b0001;
      moves_vld = 1'b1;
      @(negedge clk);
      moves_vld = 1'b0;
      moves     = 4'b0000;
      @(negedge clk);
      chk("t8_late_done", 32'(step_done), 0);
      chk("t8_late_x", 32'(pos_x), 320);
      attempt("t8b", 4'b0001, 320, 240, 320, 240, 0, 1);

`ifdef MOVE_TIMEOUT_EN
      // unanswered query times out
      ticks(4);
      wait_query("t9w");
      n = 0;
      while (query_vld && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("t9_req_cycles", 32'(n), 64);
      chk("t9_qerr", 32'(q_err), 1);
      chk("t9_qvld", 32'(query_vld), 0);
      chk("t9_stall", 32'(stalled), 1);
      chk("t9_done", 32'(step_done), 0);
      chk("t9_x", 32'(pos_x), 320);
      @(negedge clk);
      chk("t9_qerr_pulse", 32'(q_err), 0);
`else
      n = 0;
      chk("t9_qerr_tied", 32'(q_err) + 32'(n), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
